// File: rtl/present_bus_master.sv
// Streaming-to-register bridge for the PRESENT cipher peripheral: writes key/data/control,
// pulses load, waits out the core latency, then reads the 64-bit result back.
module present_bus_master #(
    parameter int WAIT_CYCLES = 40,
    parameter bit KEY_CACHE   = 1'b1
) (
    input  logic        clk,
    input  logic        iReset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [79:0] s_key,
    input  logic [63:0] s_data,
    input  logic        s_decrypt,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        busy,
    output logic        oChipselect_n,
    output logic        oWrite_n,
    output logic        oRead_n,
    output logic [3:0]  oAddress,
    output logic [31:0] odat,
    input  logic [31:0] idat
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CTRL, S_WR_K3, S_WR_K2, S_WR_K1, S_WR_D5, S_WR_D4,
        S_WR_LOAD, S_CLR_LOAD, S_WAIT, S_RD7, S_RD6, S_CAP6, S_OUT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [79:0]      key_p0;
    logic [63:0]      data_p0;
    logic             dec_p0;
    logic [79:0]      cache_key;
    logic             cache_vld;
    logic             cache_hit;

    assign cache_hit = KEY_CACHE && cache_vld && (key_p0 == cache_key);
    assign s_ready   = (state == S_IDLE);
    assign m_valid   = (state == S_OUT);
    assign busy      = (state != S_IDLE);

    // Control state: FSM, wait counter, cache valid flag and result register.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cache_vld <= 1'b0;
            m_data    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLR_LOAD)
                cnt <= CNT_LOAD;
            else if (state == S_WAIT && cnt != CNT_ONE)
                cnt <= cnt - CNT_ONE;
            if (state == S_WR_K3)
                cache_vld <= 1'b1;
            // idat lags the read strobe by one cycle, so RD6 sees the RD7 data.
            if (state == S_RD6)
                m_data[63:32] <= idat;
            if (state == S_CAP6)
                m_data[31:0] <= idat;
        end
    end

    // Request fields and cached key carry no reset; cache_vld qualifies the cache.
    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            key_p0  <= s_key;
            data_p0 <= s_data;
            dec_p0  <= s_decrypt;
        end
        if (state == S_WR_K3)
            cache_key <= key_p0;
    end

    always_comb begin
        state_nxt     = state;
        oChipselect_n = 1'b1;
        oWrite_n      = 1'b1;
        oRead_n       = 1'b1;
        oAddress      = 4'h0;
        odat          = 32'h0;
        case (state)
            S_IDLE:     if (s_valid) state_nxt = S_WR_CTRL;
            S_WR_CTRL: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h8; odat = {31'h0, dec_p0};
                state_nxt = cache_hit ? S_WR_D5 : S_WR_K3;
            end
            S_WR_K3: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h3; odat = key_p0[79:48];
                state_nxt = S_WR_K2;
            end
            S_WR_K2: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h2; odat = key_p0[47:16];
                state_nxt = S_WR_K1;
            end
            S_WR_K1: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h1; odat = {16'h0, key_p0[15:0]};
                state_nxt = S_WR_D5;
            end
            S_WR_D5: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h5; odat = data_p0[63:32];
                state_nxt = S_WR_D4;
            end
            S_WR_D4: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h4; odat = data_p0[31:0];
                state_nxt = S_WR_LOAD;
            end
            S_WR_LOAD: begin
                oChipselect_n = 1'b0; oWrite_n = 1'b0;
                oAddress = 4'h0; odat = 32'h1;
                state_nxt = S_CLR_LOAD;
            end
            S_CLR_LOAD: begin
                oChipselect_n = 1'b0;
                state_nxt = S_WAIT;
            end
            S_WAIT:     if (cnt == CNT_ONE) state_nxt = S_RD7;
            S_RD7: begin
                oChipselect_n = 1'b0; oRead_n = 1'b0; oAddress = 4'h7;
                state_nxt = S_RD6;
            end
            S_RD6: begin
                oChipselect_n = 1'b0; oRead_n = 1'b0; oAddress = 4'h6;
                state_nxt = S_CAP6;
            end
            S_CAP6: begin
                oChipselect_n = 1'b0; oAddress = 4'h6;
                state_nxt = S_OUT;
            end
            S_OUT:      if (m_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/present_bus_master.md
# present_bus_master

Bus initiator that drives the PRESENT cipher register interface (chip-select/write/read, 4-bit address, 32-bit data) on behalf of a streaming client. Accepts one 64-bit block, 80-bit key and direction flag over a valid/ready handshake. Performs the register write sequence, pulses load, waits a fixed compute interval, then reads back the 64-bit result and presents it on a valid/ready output. Sits between a streaming datapath and the memory-mapped PRESENT peripheral, replacing CPU-driven register pokes.

## Interface
- WAIT_CYCLES, 40: idle cycles between load release and first result read; must cover core latency; minimum 1.
- KEY_CACHE, 1: when 1, key writes are skipped if the key equals the last key written since reset.
- clk  in  1  clock.
- iReset_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  request valid.
- s_ready  out  1  request accepted when s_valid && s_ready at a clk edge.
- s_key  in  80  cipher key.
- s_data  in  64  plaintext or ciphertext block.
- s_decrypt  in  1  direction, written to control register bit 0.
- m_valid  out  1  result valid; held until accepted.
- m_ready  in  1  result accepted when m_valid && m_ready.
- m_data  out  64  result block.
- busy  out  1  high in every state except IDLE.
- oChipselect_n  out  1  bus select, active-low.
- oWrite_n  out  1  bus write strobe, active-low.
- oRead_n  out  1  bus read strobe, active-low.
- oAddress  out  4  bus register address.
- odat  out  32  bus write data.
- idat  in  32  bus read data; registered by the slave, valid the cycle after the read strobe.

## Operation
- Register map driven: 0x0 load (bit 0), 0x1 key[15:0] (data[15:0], upper bits 0), 0x2 key[47:16], 0x3 key[79:48], 0x4 data[31:0], 0x5 data[63:32], 0x6 result[31:0], 0x7 result[63:32], 0x8 control (bit 0 = s_decrypt).
- Request fields are latched at acceptance; inputs are ignored afterwards.
- FSM: IDLE -> WR_CTRL -> WR_K3 -> WR_K2 -> WR_K1 -> WR_D5 -> WR_D4 -> WR_LOAD -> CLR_LOAD -> WAIT -> RD7 -> RD6 -> CAP6 -> OUT -> IDLE.
- Key-cache hit (KEY_CACHE=1, cache valid, latched key equal to cached key): WR_CTRL -> WR_D5, skipping WR_K3..WR_K1. On any key write the cache is loaded and marked valid.
- WR_* states: cs_n=0, write_n=0, read_n=1, address/odat per map; one cycle each. WR_LOAD writes 1 to address 0x0.
- CLR_LOAD: cs_n=0, write_n=1, read_n=1 for one cycle; this drops the slave's load pulse.
- WAIT: bus idle (cs_n=1); down-counter loaded with WAIT_CYCLES, exit when it reaches 1.
- RD7: cs_n=0, read_n=0, address 0x7. RD6: same, address 0x6; sample idat into m_data[63:32]. CAP6: cs_n=0, strobes high, address 0x6; sample idat into m_data[31:0].
- OUT: m_valid=1, bus idle; on m_ready go to IDLE, m_valid drops next cycle.
- Bus idle value (IDLE, WAIT, OUT): cs_n=1, write_n=1, read_n=1, address 0, odat 0.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=0, busy=0, oChipselect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, odat=0. Key cache invalid.
- s_ready=1 only in IDLE; at most one request in flight; no request is accepted in the cycle m_valid is accepted.
- Acceptance edge = cycle 0. WR_CTRL is cycle 1. With key writes, CAP6 is cycle 11+WAIT_CYCLES and m_valid rises cycle 12+WAIT_CYCLES. On cache hit, m_valid rises cycle 9+WAIT_CYCLES.
- m_data stable while m_valid=1; m_valid holds indefinitely under m_ready=0.
- Reset asserted mid-operation: all outputs return to reset values immediately, the FSM goes to IDLE, and the cache is invalidated. Any partially written slave state is discarded by the next full sequence.
- Only one strobe (write_n or read_n) is ever low in a cycle, and only when cs_n=0.

## Test plan
- Encrypt, key=0, data=0, s_decrypt=0 -> bus writes 0x8=0, 0x3=0, 0x2=0, 0x1=0, 0x5=0, 0x4=0, 0x0=1 in order; m_data=0x5579C1387B228445 with m_valid at cycle 12+WAIT_CYCLES.
- Repeat with the same key, data=0xFFFFFFFFFFFFFFFF -> no writes to 0x1-0x3; m_valid at cycle 9+WAIT_CYCLES.
- Key=all-ones, data=all-ones, encrypt -> key writes reissued, 0x1 written 0x0000FFFF; m_data=0x3333DCD3213210D2.
- Decrypt, key=0, data=0x5579C1387B228445 -> 0x8 written 1; m_data=0.
- Hold m_ready=0 for 20 cycles after m_valid -> m_valid and m_data stable, s_ready=0, bus idle; result accepted on m_ready=1, s_ready=1 next cycle.
- Assert iReset_n low during WAIT -> outputs at reset values at once; the next request with the previous key performs full key writes.
